// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-back arbiter with pending long-latency write scoreboard
// Define RF_WB_ARB_STARVE_EN to compile in the port L starvation guard (STARVE_LIMIT).
module rf_wb_arbiter #(
    parameter int REG_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_p_valid,
    output logic                     o_p_ready,
    input  logic [ADDR_WIDTH-1:0]    i_p_addr,
    input  logic [REG_WIDTH-1:0]     i_p_data,
    input  logic                     i_l_valid,
    output logic                     o_l_ready,
    input  logic [ADDR_WIDTH-1:0]    i_l_addr,
    input  logic [REG_WIDTH-1:0]     i_l_data,
    input  logic                     i_alloc_valid,
    input  logic [ADDR_WIDTH-1:0]    i_alloc_addr,
    output logic [2**ADDR_WIDTH-1:0] o_busy,
    output logic                     o_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_wr_addr,
    output logic [REG_WIDTH-1:0]     o_wr_data
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic                  w_grant_p;
    logic                  w_grant_l;
    logic                  w_starved;
    logic                  w_xfer_valid;
    logic [ADDR_WIDTH-1:0] w_xfer_addr;
    logic [REG_WIDTH-1:0]  w_xfer_data;
    logic [NUM_REGS-1:0]   w_busy_next;

    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [REG_WIDTH-1:0]  r_wr_data;
    logic [NUM_REGS-1:0]   r_busy;

`ifdef RF_WB_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts consecutive cycles L waits; any cycle L is idle or wins restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= '0;
        end else if (i_l_valid && !w_grant_l) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end
`else
    // Strict priority build: the limit has no effect.
    assign w_starved = 1'b0 & (STARVE_LIMIT >= 1);
`endif

    // L wins when alone, on an address collision (it is the older write), or when starved.
    always_comb begin
        w_grant_p = 1'b0;
        w_grant_l = 1'b0;
        if (!i_reset) begin
            if (i_l_valid && (!i_p_valid || (i_p_addr == i_l_addr) || w_starved)) begin
                w_grant_l = 1'b1;
            end else if (i_p_valid) begin
                w_grant_p = 1'b1;
            end
        end
    end

    assign w_xfer_valid = w_grant_p | w_grant_l;
    assign w_xfer_addr  = w_grant_l ? i_l_addr : i_p_addr;
    assign w_xfer_data  = w_grant_l ? i_l_data : i_p_data;

    // Allocation is applied after the clear so a same-cycle re-allocation stays pending.
    always_comb begin
        w_busy_next = r_busy;
        if (w_grant_l) begin
            w_busy_next[i_l_addr] = 1'b0;
        end
        if (i_alloc_valid) begin
            w_busy_next[i_alloc_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= '0;
        end else begin
            r_wr_en <= w_xfer_valid && (w_xfer_addr != '0);
            if (w_xfer_valid) begin
                r_wr_addr <= w_xfer_addr;
                r_wr_data <= w_xfer_data;
            end
            r_busy <= w_busy_next;
        end
    end

    assign o_p_ready = w_grant_p;
    assign o_l_ready = w_grant_l;
    assign o_busy    = r_busy;
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the CPU register file's single write port. It shares the port between the in-order pipeline write-back (port P) and the long-latency unit write-back (port L, used by loads and the divider), using valid/ready handshakes. It tracks destination registers with an outstanding long-latency write so decode can stall on RAW/WAW hazards. It sits between the write-back stage and the register file's write inputs.

## Interface
- REG_WIDTH, 32, data width of a register
- ADDR_WIDTH, 5, register address width (32 registers)
- STARVE_LIMIT, 4, consecutive lost arbitrations after which L is forced to win (≥1)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_p_valid / o_p_ready  in/out  1  port P handshake
- i_p_addr / i_p_data  in  ADDR_WIDTH / REG_WIDTH  port P destination and result
- i_l_valid / o_l_ready  in/out  1  port L handshake
- i_l_addr / i_l_data  in  ADDR_WIDTH / REG_WIDTH  port L destination and result
- i_alloc_valid  in  1  a long-latency instruction issues this cycle
- i_alloc_addr  in  ADDR_WIDTH  its destination register
- o_busy  out  2**ADDR_WIDTH  per-register pending-long-latency-write flags
- o_wr_en / o_wr_addr / o_wr_data  out  1 / ADDR_WIDTH / REG_WIDTH  registered register-file write port

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. A requester holds valid, addr and data stable until accepted. Ready is combinational from the valids and the state, and may depend on valid.
- At most one of o_p_ready / o_l_ready is high per cycle. Ready is never high without its own valid.
- Grant rules, evaluated in order:
  1. Only one requester valid → grant it.
  2. Both valid and i_p_addr == i_l_addr → grant L. L is older, which preserves WAW order.
  3. Both valid and starve_cnt == STARVE_LIMIT → grant L.
  4. Otherwise grant P.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments when L is valid and not granted.
  - Clears when L is granted or L is not valid.
  - Saturates at STARVE_LIMIT.
- Accepted transfer with addr != 0: o_wr_en=1, addr and data registered next cycle.
- Accepted transfer with addr == 0: the handshake completes normally but o_wr_en stays 0. x0 is never written.
- Scoreboard, per bit i:
  - Set by i_alloc_valid with i_alloc_addr==i (i != 0).
  - Cleared by an accepted L transfer with i_l_addr==i.
  - Set and clear on the same register in the same cycle → set wins. This is a new allocation.
  - Bit 0 is always 0. Port P transfers never touch the scoreboard.

## Timing
- Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, starve_cnt=0.
- While i_reset is high, o_p_ready=o_l_ready=0.
- Reset mid-operation:
  - A write registered in the previous cycle still drives the port that cycle.
  - All pending state (busy bits, starve_cnt) is cleared on the reset edge.
  - The first write after reset deasserts is the first new handshake.
- Latency: handshake in cycle N → o_wr_en/addr/data valid in cycle N+1, for exactly one cycle. The register file commits on the falling edge of cycle N+1.
- o_busy updates on the edge ending the alloc or L-accept cycle. A clear caused by L accepted in cycle N shows o_busy[i]=0 in cycle N+1, together with o_wr_en.
- Throughput: one write per cycle. Back-to-back grants to the same port are allowed.
- o_wr_en is deasserted in any cycle following a cycle with no accepted nonzero-address transfer.

## Configuration
- RF_WB_ARB_STARVE_EN defined:
  - starve_cnt and rule 3 are compiled in.
  - L waits at most STARVE_LIMIT cycles while P is continuously valid with different addresses.
- Not defined:
  - No counter. Strict priority: P wins except on the same-address rule 2.
  - L can starve indefinitely. STARVE_LIMIT is ignored.

## Test plan
- Single ports: P valid addr=5 data=0xA5A5 → o_p_ready=1 same cycle, next cycle o_wr_en=1 addr=5 data=0xA5A5; repeat on L with addr=7, same result.
- Contention, different addresses, STARVE_LIMIT=4, macro on: P and L valid continuously (P addr 3, L addr 9) → P granted for 4 cycles, L granted in the 5th, then P again. With the macro off → L never granted while P is valid.
- Same-address collision: P and L both valid to addr 12 → L granted first (L data written), P granted the next cycle → final writes in order L then P.
- x0 drop: P valid addr=0 data=0xFFFF → o_p_ready=1, o_wr_en stays 0 the next cycle; alloc to addr 0 leaves o_busy=0.
- Scoreboard: alloc addr=8 → o_busy[8]=1 the next cycle; L accepted addr=8 → o_busy[8]=0 the next cycle. Alloc addr=8 in the same cycle as L accepted addr=8 → o_busy[8] stays 1.
- Reset mid-operation: o_busy[4]=1, starve_cnt=3, L pending → assert i_reset for 1 cycle → readies low during reset, then o_busy=0, starve_cnt=0, o_wr_en=0; L is granted the first cycle after reset if P is idle.
